// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: shared types and constants for the UART receive bit timer.
//   bit_kind_t : tag carried with every mid-bit sample strobe.
//   state_t    : rx_bit_timer FSM states.
//   MIN_PERIOD : smallest bit_period that still leaves a non-zero half period.
package rx_timer_pkg;

  typedef enum logic [1:0] {
    BK_NONE   = 2'd0,
    BK_DATA   = 2'd1,
    BK_PARITY = 2'd2,
    BK_STOP   = 2'd3
  } bit_kind_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CENTER = 2'd1,
    BITS   = 2'd2
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: programmable modulo counter.
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous clear to 0 (has priority over count_enable)
//   count_enable  : advance the count this cycle
//   rollover_val  : modulus; the count runs 0 .. rollover_val-1 (must be >= 1)
//   count_out     : current count
//   rollover_flag : high in the cycle the count sits on rollover_val-1 while
//                   enabled, i.e. the cycle whose edge wraps the count to 0
module flex_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            count_enable,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out,
  output logic            rollover_flag
);

  logic [SIZE-1:0] count_q;
  logic [SIZE-1:0] count_d;

  assign rollover_flag = count_enable && (count_q == rollover_val - SIZE'(1));
  assign count_out     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = rollover_flag ? '0 : count_q + SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-timing engine for the UART receive path.
// Waits half a bit period after the start-bit edge, then issues one mid-bit
// shift_strobe per data / parity / stop bit, tagged with bit_kind, and pulses
// packet_done together with the last strobe.
//
// Ports:
//   clk, n_rst   : clock (rising edge), asynchronous active-low reset
//   start_timer  : one-cycle pulse at the start-bit falling edge
//   abort        : synchronous cancel of the frame in progress
//   bit_period   : clocks per bit (latched at start)
//   data_size    : data bits per frame (latched at start)
//   parity_en    : frame carries a parity bit (latched at start)
//   two_stop     : 1 = two stop bits, 0 = one (latched at start)
//   shift_strobe : one-cycle mid-bit sample strobe
//   bit_kind     : kind of the bit being strobed, BK_NONE otherwise
//   packet_done  : one-cycle pulse coincident with the final strobe
//   busy         : high while a frame is being timed
//   cfg_err      : one-cycle pulse when a start is rejected (bit_period<2 or
//                  data_size==0)
//
// Build option: define RX_BIT_TIMER_PARITY_EN to honour parity_en. Without it
// parity_en is ignored and no BK_PARITY strobe is ever produced.
//
// Start handshake: start_timer has no ready. A pulse is accepted only when the
// FSM is IDLE, busy is low and abort is low; any other pulse is dropped. busy
// stays high through the cycle carrying packet_done, so the earliest accepted
// follow-on start is sampled one edge after busy falls.
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int PERIOD_W = 14,
  parameter int SIZE_W   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start_timer,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [SIZE_W-1:0]   data_size,
  input  logic                parity_en,
  input  logic                two_stop,
  output logic                shift_strobe,
  output bit_kind_t           bit_kind,
  output logic                packet_done,
  output logic                busy,
  output logic                cfg_err
);

  // Wide enough for data_size max + parity + 2 stop bits.
  localparam int IDX_W = SIZE_W + 2;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                par_q, par_d;
  logic [IDX_W-1:0]    total_q, total_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                strobe_q, strobe_d;
  bit_kind_t           kind_q, kind_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cfg_err_q, cfg_err_d;

  logic                par_eff;
  logic                cfg_ok;
  logic [IDX_W-1:0]    next_idx;
  bit_kind_t           next_kind;
  logic                last_bit;
  logic                cnt_clear;
  logic                cnt_enable;
  logic [PERIOD_W-1:0] cnt_rollover_val;
  logic [PERIOD_W-1:0] cnt_count_unused;
  logic                tick;

`ifdef RX_BIT_TIMER_PARITY_EN
  assign par_eff = parity_en;
`else
  logic parity_en_unused;
  assign parity_en_unused = parity_en;
  assign par_eff          = 1'b0;
`endif

  assign cfg_ok = (bit_period >= PERIOD_W'(MIN_PERIOD)) && (data_size != '0);

  // Period counter: H clocks in CENTER, P clocks per bit in BITS. Held clear
  // in IDLE so a new frame always starts counting from zero.
  assign cnt_rollover_val = (state_q == BITS) ? period_q : half_q;
  assign cnt_enable       = (state_q != IDLE);
  assign cnt_clear        = (state_q == IDLE) || ((state_q == CENTER) && tick);

  flex_counter #(
    .SIZE(PERIOD_W)
  ) u_period_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_enable),
    .rollover_val (cnt_rollover_val),
    .count_out    (cnt_count_unused),
    .rollover_flag(tick)
  );

  // Kind of the bit about to be strobed (1-based index next_idx).
  assign next_idx = idx_q + IDX_W'(1);
  assign last_bit = (next_idx == total_q);

  always_comb begin
    next_kind = BK_STOP;
    if (next_idx <= IDX_W'(size_q)) begin
      next_kind = BK_DATA;
    end else if (par_q && (next_idx == IDX_W'(size_q) + IDX_W'(1))) begin
      next_kind = BK_PARITY;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    half_d    = half_q;
    size_d    = size_q;
    par_d     = par_q;
    total_d   = total_q;
    idx_d     = idx_q;
    strobe_d  = 1'b0;
    kind_d    = BK_NONE;
    done_d    = 1'b0;
    busy_d    = busy_q;
    cfg_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_timer && !abort && !busy_q) begin
          if (cfg_ok) begin
            period_d = bit_period;
            half_d   = bit_period >> 1;
            size_d   = data_size;
            par_d    = par_eff;
            total_d  = IDX_W'(data_size) + IDX_W'(par_eff) + IDX_W'(1)
                     + IDX_W'(two_stop);
            idx_d    = '0;
            busy_d   = 1'b1;
            state_d  = CENTER;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CENTER: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          state_d = BITS;
        end
      end
      BITS: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          strobe_d = 1'b1;
          kind_d   = next_kind;
          idx_d    = next_idx;
          if (last_bit) begin
            // busy stays high for this cycle; IDLE drops it on the next edge.
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      half_q    <= '0;
      size_q    <= '0;
      par_q     <= 1'b0;
      total_q   <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      kind_q    <= BK_NONE;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      half_q    <= half_d;
      size_q    <= size_d;
      par_q     <= par_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      kind_q    <= kind_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign shift_strobe = strobe_q;
  assign bit_kind     = kind_q;
  assign packet_done  = done_q;
  assign busy         = busy_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed scoreboard bench for rx_bit_timer.
// Each frame pushes its hand-computed strobe schedule (absolute cycle, kind,
// done) into exp_q; a negedge monitor pops and compares on every strobe or
// packet_done. Honours RX_BIT_TIMER_PARITY_EN for the parity frame.
module tb_rx_bit_timer;
  import rx_timer_pkg::*;

  localparam int PERIOD_W = 14;
  localparam int SIZE_W   = 4;
  localparam int W        = 36; // {cycle[31:0], strobe, kind[1:0], done}

  logic                clk;
  logic                n_rst;
  logic                start_timer;
  logic                abort;
  logic [PERIOD_W-1:0] bit_period;
  logic [SIZE_W-1:0]   data_size;
  logic                parity_en;
  logic                two_stop;
  logic                shift_strobe;
  bit_kind_t           bit_kind;
  logic                packet_done;
  logic                busy;
  logic                cfg_err;

  rx_bit_timer #(
    .PERIOD_W(PERIOD_W),
    .SIZE_W  (SIZE_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start_timer (start_timer),
    .abort       (abort),
    .bit_period  (bit_period),
    .data_size   (data_size),
    .parity_en   (parity_en),
    .two_stop    (two_stop),
    .shift_strobe(shift_strobe),
    .bit_kind    (bit_kind),
    .packet_done (packet_done),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_v;
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int e, input bit_kind_t k, input bit d);
    exp_q.push_back({32'(e), 1'b1, 2'(k), d});
  endtask

  always @(negedge clk) begin
    if (n_rst && (shift_strobe || packet_done)) begin
      obs_v = {32'(cyc), shift_strobe, 2'(bit_kind), packet_done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cycle %0d strobe %0b kind %0d done %0b, required none",
                 cyc, shift_strobe, bit_kind, packet_done);
      end else begin
        exp_v = exp_q.pop_front();
        if (exp_v !== obs_v) begin
          errors++;
          $display("FAIL strobe_event: got cycle %0d strobe %0b kind %0d done %0b, required cycle %0d strobe %0b kind %0d done %0b",
                   obs_v[35:4], obs_v[3], obs_v[2:1], obs_v[0],
                   exp_v[35:4], exp_v[3], exp_v[2:1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is edge 0 and e0 is the
  // cycle count seen at negedges after it.
  task automatic start_frame(input int p, input int n, input bit par,
                             input bit two, output int e0);
    bit_period  = PERIOD_W'(p);
    data_size   = SIZE_W'(n);
    parity_en   = par;
    two_stop    = two;
    start_timer = 1'b1;
    e0          = cyc + 1;
    @(negedge clk);
    start_timer = 1'b0;
  endtask

  task automatic drain(input string name, input int t);
    goto_cyc(t);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // P=10 N=8 one stop: H=5, strobes at 15..95, DATA x8 then STOP.
  task automatic push_p10n8(input int e0, input int count);
    for (int i = 1; i <= count; i++)
      push_exp(e0 + 5 + 10 * i, (i <= 8) ? BK_DATA : BK_STOP, i == 9);
  endtask

  // ---------------- stimulus ----------------
  int e0;
  int e1;

  initial begin
    n_rst       = 1'b0;
    start_timer = 1'b0;
    abort       = 1'b0;
    bit_period  = '0;
    data_size   = '0;
    parity_en   = 1'b0;
    two_stop    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobe", int'(shift_strobe), 0);
    check("reset_done", int'(packet_done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_kind", int'(bit_kind), int'(BK_NONE));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with an ignored mid-frame start at edge 20.
    start_frame(10, 8, 1'b0, 1'b0, e0);
    push_p10n8(e0, 9);
    check("t1_busy_edge0", int'(busy), 1);
    goto_cyc(e0 + 19);
    bit_period  = PERIOD_W'(3);
    data_size   = SIZE_W'(1);
    start_timer = 1'b1;
    @(negedge clk);
    start_timer = 1'b0;
    bit_period  = PERIOD_W'(10);
    data_size   = SIZE_W'(8);
    goto_cyc(e0 + 95);
    check("t1_busy_at_done", int'(busy), 1);
    goto_cyc(e0 + 96);
    check("t1_busy_after_done", int'(busy), 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Back-to-back start in the first cycle busy is low; P=3 N=1, H=1.
    start_frame(3, 1, 1'b0, 1'b0, e1);
    check("b2b_start_edge", e1, e0 + 97);
    push_exp(e1 + 4, BK_DATA, 1'b0);
    push_exp(e1 + 7, BK_STOP, 1'b1);
    goto_cyc(e1 + 8);
    check("b2b_busy_after", int'(busy), 0);
    drain("b2b_queue_empty", e1 + 12);

    // P=4 N=5 parity two-stop: H=2.
    start_frame(4, 5, 1'b1, 1'b1, e0);
`ifdef RX_BIT_TIMER_PARITY_EN
    for (int i = 1; i <= 8; i++)
      push_exp(e0 + 2 + 4 * i, (i <= 5) ? BK_DATA : ((i == 6) ? BK_PARITY : BK_STOP), i == 8);
`else
    for (int i = 1; i <= 7; i++)
      push_exp(e0 + 2 + 4 * i, (i <= 5) ? BK_DATA : BK_STOP, i == 7);
`endif
    drain("par_queue_empty", e0 + 45);
    check("par_busy_after", int'(busy), 0);

    // Illegal configurations.
    start_frame(1, 8, 1'b0, 1'b0, e0);
    check("cfg_p1_err", int'(cfg_err), 1);
    check("cfg_p1_busy", int'(busy), 0);
    @(negedge clk);
    check("cfg_p1_err_pulse", int'(cfg_err), 0);
    start_frame(10, 0, 1'b0, 1'b0, e0);
    check("cfg_n0_err", int'(cfg_err), 1);
    check("cfg_n0_busy", int'(busy), 0);
    @(negedge clk);
    check("cfg_n0_err_pulse", int'(cfg_err), 0);
    goto_cyc(e0 + 50);
    check("cfg_busy_idle", int'(busy), 0);
    drain("cfg_no_strobe", e0 + 51);

    // Abort sampled at edge 41.
    start_frame(10, 8, 1'b0, 1'b0, e0);
    push_p10n8(e0, 3);
    goto_cyc(e0 + 40);
    check("abort_busy_before", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after", int'(busy), 0);
    drain("abort_queue_empty", e0 + 110);

    // Abort coincident with the final strobe.
    start_frame(10, 8, 1'b0, 1'b0, e0);
    push_p10n8(e0, 8);
    goto_cyc(e0 + 94);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_strobe", int'(shift_strobe), 0);
    check("abort_last_done", int'(packet_done), 0);
    check("abort_last_busy", int'(busy), 0);
    drain("abort_last_queue_empty", e0 + 110);

    // abort + start together in IDLE: no start.
    bit_period  = PERIOD_W'(10);
    data_size   = SIZE_W'(8);
    start_timer = 1'b1;
    abort       = 1'b1;
    @(negedge clk);
    start_timer = 1'b0;
    abort       = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_cfg_err", int'(cfg_err), 0);
    repeat (20) @(negedge clk);

    // Fresh full frame after aborts.
    start_frame(10, 8, 1'b0, 1'b0, e0);
    push_p10n8(e0, 9);
    drain("fresh_queue_empty", e0 + 100);

    // Asynchronous reset at edge 50.
    start_frame(10, 8, 1'b0, 1'b0, e0);
    push_p10n8(e0, 4);
    goto_cyc(e0 + 49);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("rst_strobe", int'(shift_strobe), 0);
    check("rst_done", int'(packet_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_kind", int'(bit_kind), int'(BK_NONE));
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    drain("rst_queue_empty", e0 + 150);
    check("rst_busy_final", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
